// File: rtl/serial_alu_pkg.sv
// Shared opcode and controller state encodings for the bit-serial ALU.
package serial_alu_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // ADD and SUB are the only opcodes that produce a carry chain.
  function automatic logic is_arith(op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/serial_alu_ctrl_alu1bit.sv
// Combinational 1-bit ALU slice: NOR, XOR, full-add, and subtract via inverted B.
import serial_alu_pkg::*;

module alu1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);

  logic b_eff;

  always_comb begin
    b_eff = b ^ (op == OP_SUB);
    s     = 1'b0;
    cout  = 1'b0;
    case (op)
      OP_NOR: s = ~(a | b);
      OP_XOR: s = a ^ b;
      default: begin
        s    = a ^ b_eff ^ cin;
        cout = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial N-bit ALU sequencer around one alu1bit slice, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ALU_OVF_EN.
import serial_alu_pkg::*;

module serial_alu_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_next;
  op_e              op_q;
  logic             carry;
  logic             s_bit;
  logic             c_bit;

  alu1bit u_slice (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .op   (op_q),
    .s    (s_bit),
    .cout (c_bit)
  );

  // Partial result lives in res_sh; result is only written once all bits are in.
  assign res_next = {s_bit, res_sh};
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= OP_NOR;
      result <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= op_e'(op);
            cnt   <= '0;
            carry <= (op == OP_SUB);
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          res_sh <= res_next[WIDTH-1:1];
          carry  <= c_bit;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            result <= res_next;
            cout   <= is_arith(op_q) ? c_bit : 1'b0;
`ifdef SERIAL_ALU_OVF_EN
            // carry FF holds the carry into the MSB during the last bit
            ovf    <= is_arith(op_q) ? (carry ^ c_bit) : 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_alu_ctrl.md
# serial_alu_ctrl

Bit-serial sequencer that runs an N-bit ALU operation through a single 1-bit ALU slice, LSB first, one bit per clock. It latches operands and opcode on a start request, drives the slice with the current operand bits and a registered carry, shifts the result in, and reports completion with a one-cycle `done` pulse. It sits between the register/operand source and the existing `alu1bit` cell, turning that combinational slice into a multi-cycle N-bit unit.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; sampled only in IDLE or DONE.
- `a`  in  WIDTH: operand A, latched on accepted start.
- `b`  in  WIDTH: operand B, latched on accepted start.
- `op`  in  2: 00 NOR, 01 XOR, 10 ADD, 11 SUB (A−B); latched on accepted start.
- `busy`  out  1: high while bits are being processed (RUN).
- `done`  out  1: one-cycle pulse, result valid.
- `result`  out  WIDTH: completed result, held until the next accepted start.
- `cout`  out  1: final carry for ADD/SUB (SUB: 1 = no borrow); 0 for NOR/XOR.
- `ovf`  out  1: signed overflow; present only with `SERIAL_ALU_OVF_EN`.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE with `start`=1 → RUN; latch `a`, `b`, `op`; clear bit counter; seed carry FF with 1 for SUB, 0 otherwise.
- DONE with `start`=0 → IDLE. DONE lasts exactly one cycle.
- RUN, each cycle: drive slice with `a_sh[0]`, `b_sh[0]`, carry FF, and latched op; shift slice `s` into result register MSB side (right shift), so after WIDTH shifts bit 0 sits at LSB; update carry FF from slice `cout`; shift operand registers right; increment counter.
- RUN at counter = WIDTH−1 → DONE; final carry captured as `cout` (forced 0 for NOR/XOR).
- `start` in RUN is ignored (no queuing). Changes on `a`/`b`/`op` after acceptance have no effect.
- `result` updates only at RUN→DONE; it is not exposed mid-shift, so it stays stable between operations.
- Arithmetic is modulo 2^WIDTH; SUB = A + ~B + 1.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `cout`=0, `ovf`=0, state IDLE, counter 0, carry FF 0.
- Start accepted at edge k → `busy`=1 in cycles k+1 … k+WIDTH; `done`=1 and valid `result`/`cout` in cycle k+WIDTH+1. Latency WIDTH+1 cycles start-to-done.
- Back-to-back: `start` high during the `done` cycle is accepted; `busy` rises next cycle. Throughput one op per WIDTH+1 cycles.
- `rst` at any point, including mid-RUN, wins over `start`: next cycle IDLE with all reset values; partial result discarded.
- Clock period must exceed the slice's worst combinational path (carry in → `cout`, op → `s`) plus carry-FF setup.

## Configuration
- `SERIAL_ALU_OVF_EN` defined: `ovf` port exists; on the final RUN cycle, `ovf` = carry into MSB XOR carry out for ADD/SUB, 0 for NOR/XOR; registered with `result`, held until next accepted start.
- Undefined: no `ovf` port, no extra flop; all other behaviour identical.

## Structure
- Package `serial_alu_pkg`: opcode enum (OP_NOR=2'b00, OP_XOR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11) and state enum (IDLE, RUN, DONE).
- One sub-module instance: `alu1bit` as the bit-slice; the controller owns all registers (operand shifters, result shifter, carry FF, counter sized `$clog2(WIDTH)`, state).

## Test plan
- Reset, WIDTH=8: hold `rst` 2 cycles → `busy`=0, `done`=0, `result`=8'h00, `cout`=0.
- ADD 8'hF0 + 8'h20, start at edge k → `busy` cycles k+1…k+8, `done` in cycle k+9, `result`=8'h10, `cout`=1.
- SUB 8'h05 − 8'h07 → `result`=8'hFE, `cout`=0; then SUB 8'h07 − 8'h05 back-to-back on `done` → `result`=8'h02, `cout`=1.
- NOR 8'hA5, 8'h0F → 8'h50, `cout`=0; XOR same operands → 8'hAA, `cout`=0.
- Start ADD 8'h01+8'h01, pulse `start` again and change `a`/`b` mid-RUN → ignored, `result`=8'h02; assert `rst` at 4th RUN cycle of a later op → IDLE next cycle, outputs reset, no `done`; fresh op then completes normally.
- With `SERIAL_ALU_OVF_EN`: ADD 8'h7F + 8'h01 → `result`=8'h80, `ovf`=1; SUB 8'h80 − 8'h01 → 8'h7F, `ovf`=1; ADD 8'h01 + 8'h01 → `ovf`=0.
